// File: rtl/seg_frame_arbiter.sv
// seg_frame_arbiter: shares the 256-bit LCD segment output between two frame
// sources. An internal prescaler produces a refresh tick. Arbitration, grant
// changes and the frame latch all happen only on tick cycles. Ownership is
// round-robin after a minimum hold time.
// Optional feature macro: SEG_BLINK_EN (blinks the masked segments with a
// phase bit that toggles every BLINK_TICKS ticks).
module seg_frame_arbiter #(
  parameter int TICK_DIV    = 400,
  parameter int HOLD_TICKS  = 8,
  parameter int BLINK_TICKS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req,
  input  logic [255:0] frame0,
  input  logic [255:0] frame1,
  input  logic [255:0] blink_mask,
  output logic [1:0]   grant,
  output logic         busy,
  output logic         tick,
  output logic [255:0] out_seg
);

  localparam int               DIV_W    = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(TICK_DIV - 1);
  localparam logic [7:0]       HOLD_MAX = 8'(HOLD_TICKS - 1);

  // The state encoding doubles as the one-hot grant vector.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } state_t;

  logic [DIV_W-1:0] div_cnt_reg;
  state_t           state_reg;
  state_t           state_next;
  logic [7:0]       hold_cnt_reg;
  logic [7:0]       hold_cnt_next;
  logic [255:0]     sel_frame;
  logic [255:0]     load_frame;

  // Refresh prescaler: counts down and reloads; tick is its zero state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg <= DIV_LOAD;
    end else if (div_cnt_reg == '0) begin
      div_cnt_reg <= DIV_LOAD;
    end else begin
      div_cnt_reg <= div_cnt_reg - 1'b1;
    end
  end

  assign tick = (div_cnt_reg == '0);

  // State and hold counter advance only on refresh ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      hold_cnt_reg <= '0;
    end else if (tick) begin
      state_reg    <= state_next;
      hold_cnt_reg <= hold_cnt_next;
    end
  end

  // Next-owner decision from this cycle's requests and the hold count.
  always_comb begin
    state_next    = state_reg;
    hold_cnt_next = hold_cnt_reg;
    case (state_reg)
      IDLE: begin
        hold_cnt_next = '0;
        if (req[0]) begin
          state_next = OWN0;
        end else if (req[1]) begin
          state_next = OWN1;
        end
      end
      OWN0: begin
        if (!req[0]) begin
          state_next    = req[1] ? OWN1 : IDLE;
          hold_cnt_next = '0;
        end else if (req[1] && (hold_cnt_reg >= HOLD_MAX)) begin
          state_next    = OWN1;
          hold_cnt_next = '0;
        end else if (hold_cnt_reg < HOLD_MAX) begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      OWN1: begin
        if (!req[1]) begin
          state_next    = req[0] ? OWN0 : IDLE;
          hold_cnt_next = '0;
        end else if (req[0] && (hold_cnt_reg >= HOLD_MAX)) begin
          state_next    = OWN0;
          hold_cnt_next = '0;
        end else if (hold_cnt_reg < HOLD_MAX) begin
          hold_cnt_next = hold_cnt_reg + 1'b1;
        end
      end
      default: begin
        state_next    = IDLE;
        hold_cnt_next = '0;
      end
    endcase
  end

  // Outputs: grant mirrors the registered state; the frame to latch follows the next owner.
  always_comb begin
    grant = state_reg;
    busy  = |state_reg;
    case (state_next)
      OWN0:    sel_frame = frame0;
      OWN1:    sel_frame = frame1;
      default: sel_frame = '0;
    endcase
  end

`ifdef SEG_BLINK_EN
  localparam int                 BLINK_W    = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  logic [BLINK_W-1:0] blink_cnt_reg;
  logic               blink_phase_reg;

  // Free-running blink phase, stepped once per tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else if (tick) begin
      if (blink_cnt_reg == BLINK_LAST) begin
        blink_cnt_reg   <= '0;
        blink_phase_reg <= ~blink_phase_reg;
      end else begin
        blink_cnt_reg <= blink_cnt_reg + 1'b1;
      end
    end
  end

  // Masked segments are blanked while the phase bit is high.
  always_comb begin
    load_frame = sel_frame & ~(blink_mask & {256{blink_phase_reg}});
  end
`else
  logic blink_mask_unused;
  assign blink_mask_unused = ^blink_mask;

  // Without blinking the selected frame goes out unchanged.
  always_comb begin
    load_frame = sel_frame;
  end
`endif

  // Segment latch: frames are sampled only on tick cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_seg <= '0;
    end else if (tick) begin
      out_seg <= load_frame;
    end
  end

endmodule

// File: tb/tb_seg_frame_arbiter.sv
// Bench for seg_frame_arbiter: directed scenarios followed by random requests,
// frames and reset pulses, checked by a scoreboard fed from a reference model.
module tb_seg_frame_arbiter;

  localparam int TD = 4;
  localparam int HT = 2;
  localparam int BT = 2;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [1:0]   req = 2'b00;
  logic [255:0] frame0 = '0;
  logic [255:0] frame1 = '0;
  logic [255:0] blink_mask = '0;
  logic [1:0]   grant;
  logic         busy;
  logic         tick;
  logic [255:0] out_seg;

  int total = 0;
  int bad = 0;

  typedef struct {
    int           owner;
    logic [255:0] seg;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur_exp;
  logic exp_tick;
  bit   done = 0;

  seg_frame_arbiter #(
    .TICK_DIV(TD),
    .HOLD_TICKS(HT),
    .BLINK_TICKS(BT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .frame0(frame0),
    .frame1(frame1),
    .blink_mask(blink_mask),
    .grant(grant),
    .busy(busy),
    .tick(tick),
    .out_seg(out_seg)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [1:0] owner_grant(input int owner);
    if (owner == 0) return 2'b01;
    if (owner == 1) return 2'b10;
    return 2'b00;
  endfunction

  // Reference model: counts edges since reset release, decides ownership on
  // each tick from the arbitration rules, and queues the expected result.
  initial begin : model
    int cyc;
    int owner;
    int hold;
    int bcnt;
    bit phase;
    exp_t e;
    cyc = 0; owner = -1; hold = 0; bcnt = 0; phase = 0; exp_tick = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        cyc = 0; owner = -1; hold = 0; bcnt = 0; phase = 0;
        exp_tick = 0;
        exp_q.delete();
      end else begin
        cyc++;
        if (cyc % TD == 0) begin
          if (owner < 0) begin
            owner = req[0] ? 0 : (req[1] ? 1 : -1);
            hold = 0;
          end else if (!req[owner]) begin
            owner = req[1-owner] ? 1 - owner : -1;
            hold = 0;
          end else if (req[1-owner] && hold >= HT - 1) begin
            owner = 1 - owner;
            hold = 0;
          end else begin
            hold = (hold + 1 > HT - 1) ? HT - 1 : hold + 1;
          end
          e.owner = owner;
          e.seg = (owner == 0) ? frame0 : ((owner == 1) ? frame1 : '0);
`ifdef SEG_BLINK_EN
          if (phase) e.seg = e.seg & ~blink_mask;
          bcnt++;
          if (bcnt == BT) begin
            bcnt = 0;
            phase = ~phase;
          end
`endif
          exp_q.push_back(e);
        end
        exp_tick = ((cyc + 1) % TD == 0);
      end
    end
  end

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0t got=%h want=%h", name, $time, got, want);
    end
  endtask

  // Monitor: on each falling edge take any newly latched expectation and
  // compare every visible output.
  initial begin : monitor
    cur_exp.owner = -1;
    cur_exp.seg = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cur_exp.owner = -1;
        cur_exp.seg = '0;
      end else if (exp_q.size() > 0) begin
        cur_exp = exp_q.pop_front();
      end
      check("tick", 256'(tick), 256'(exp_tick));
      check("grant", 256'(grant), 256'(owner_grant(cur_exp.owner)));
      check("busy", 256'(busy), 256'(cur_exp.owner >= 0));
      check("out_seg", out_seg, cur_exp.seg);
      $display("cyc t=%0t req=%b tick=%b grant=%b out_seg[31:0]=%h", $time, req, tick, grant, out_seg[31:0]);
    end
  end

  // Reset must clear the outputs without waiting for a clock edge.
  initial begin : reset_monitor
    forever begin
      @(negedge rst_n);
      #1;
      check("async_rst_grant", 256'(grant), 256'(2'b00));
      check("async_rst_seg", out_seg, '0);
      cur_exp.owner = -1;
      cur_exp.seg = '0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #4;
    rst_n = 1'b1;
  endtask

  // Stimulus
  initial begin : stim
    step(3);
    rst_n = 1'b1;
    step(14);                         // reset and idle
    req = 2'b01;
    frame0 = 256'h1F;
    step(6);
    frame0 = 256'h3E;                // mid-interval frame change
    step(8);
    req = 2'b11;                      // round-robin
    frame0 = rand256();
    frame1 = rand256();
    step(26);
    req = 2'b10;
    step(8);
    req = 2'b00;                      // release from OWN1
    step(8);
    req = 2'b01;
    frame0 = rand256();
    step(9);
    reset_pulse();                    // async reset mid-operation
    step(12);
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(3) == 0) req = 2'($urandom_range(3));
      if ($urandom_range(1) == 0) frame0 = rand256();
      if ($urandom_range(1) == 0) frame1 = rand256();
      if ($urandom_range(3) == 0) blink_mask = rand256();
      if ($urandom_range(149) == 0) reset_pulse();
      step(1);
    end
    step(2);
    done = 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin : watchdog
    #200000;
    if (!done) begin
      $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
      $fatal(1, "timeout");
    end
  end

endmodule
